fpu_add_subtract_function: RTL and testbench
============================================

# fpu_add_subtract_function

IEEE-754 floating-point adder/subtractor with a multi-cycle datapath. A start pulse launches one operation, and a `ready` flag reports completion. It returns `Data_X ± Data_Y`, rounded per `r_mode`, with overflow and underflow flags. It is the add/subtract unit of the FPU and is driven by an upstream controller through a start/ready handshake.

## Interface
- `W`, default 32: word width; 32 = single, 64 = double. Derived values: EW = 8/11, SW = 23/52.
- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: synchronous, active-high reset of the whole block.
- `rst_FSM`, in, 1: synchronous, active-high reset of the FSM only.
- `beg_FSM`, in, 1: start; sampled in IDLE or DONE.
- `Data_X`, in, W: operand X in IEEE format.
- `Data_Y`, in, W: operand Y in IEEE format.
- `add_subt`, in, 1: 0 = X+Y, 1 = X−Y.
- `r_mode`, in, 2: 00 truncate, 01 toward −inf, 10 toward +inf, 11 see Configuration.
- `overflow_flag`, out, 1: result overflowed.
- `underflow_flag`, out, 1: result underflowed.
- `ready`, out, 1: result valid.
- `final_result_ieee`, out, W: registered result.

## Operation
- States: IDLE → ALIGN → ADD → NORM → ROUND → DONE.
- IDLE/DONE with `beg_FSM`=1: register X, Y, `add_subt` and `r_mode`, clear `ready`, go to ALIGN. Inputs are ignored at all other times.
- ALIGN:
  - Effective sign of Y = `Y[W-1]` XOR `add_subt`.
  - Swap operands so that |A| ≥ |B|, comparing exponent first, then significand.
  - Right-shift B's significand (hidden 1 included) by the exponent difference, keeping guard, round and sticky bits.
  - If the shift is ≥ SW+3, B contributes only sticky.
- ADD: add the significands when the signs match, otherwise subtract (A − B). Width is SW+5 bits.
- NORM:
  - Carry out: shift right 1 and increment the exponent; the shifted-out bit joins sticky.
  - Otherwise: shift left by the leading-zero count and subtract it from the exponent.
  - Zero significand: result +0, no flags.
- ROUND:
  - Truncate: drop the extra bits.
  - Toward −inf: increment if the result is negative and any extra bit is set.
  - Toward +inf: increment if the result is positive and any extra bit is set.
  - A rounding carry renormalizes: exponent +1.
- Exponent handling:
  - Final exponent ≥ 2^EW−1: result ±Inf (exponent all ones, fraction 0), `overflow_flag`=1.
  - Final exponent ≤ 0: result ±0, `underflow_flag`=1.
- Denormal inputs (exponent 0) are treated as zero.
- Inputs with exponent all ones are not special-cased; they are processed arithmetically.
- DONE: drive `final_result_ieee` and the flags, and set `ready`=1. All three hold until the next start or a reset.

## Timing
- `rst` (sync): state IDLE; `ready`=0, both flags 0, `final_result_ieee`=0.
- `rst_FSM` (sync): state IDLE; `ready`=0, flags 0; `final_result_ieee` keeps its value.
- `rst` has priority over `rst_FSM`; `rst_FSM` has priority over `beg_FSM`.
- Latency is fixed: `beg_FSM` sampled at edge k → `ready` rises at edge k+5, regardless of data.
- `beg_FSM` held high in DONE restarts a new operation every 5 cycles.
- `rst_FSM` mid-operation aborts it; `ready` never rises for that operation.
- `beg_FSM` during ALIGN–ROUND is ignored.

## Configuration
- `FPU_ROUND_NEAREST_EN` defined: `r_mode`=11 rounds to nearest, ties to even (guard & (round | sticky | LSB)).
- Not defined: `r_mode`=11 behaves as truncate.

## Structure
- Package `fpu_pkg`:
  - FSM state enum.
  - `r_mode` encoding constants.
  - EW/SW helper functions of W.
- One sub-module, `fpu_lzd`: combinational leading-zero detector on the SW+5-bit sum, used by NORM.

## Test plan
- Reset: `rst`=1 for one edge → `ready`=0, both flags 0, `final_result_ieee`=0x00000000.
- Add: X=0x40066666 (2.1), Y=0x40466666 (3.1), `add_subt`=0, `r_mode`=01, `beg_FSM` pulsed for one cycle → 5 edges later `ready`=1, result 0x40A66666, flags 0.
- Subtract:
  - X=0x40066666, Y=0x40466666, `add_subt`=1 → 0xBF800000.
  - Swapped operands (X=0x40466666, Y=0x40066666) → 0x3F800000.
- Rounding: 0x3F800000 + 0x33800001:
  - `r_mode`=00 → 0x3F800000.
  - `r_mode`=10 → 0x3F800001.
  - `r_mode`=01 → 0x3F800000.
- Exceptions:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, `overflow_flag`=1.
  - 0x00800001 − 0x00800000 → 0x00000000, `underflow_flag`=1.
  - X=0x40066666, Y=0xC0066666 (X + (−X)), `add_subt`=0 → 0x00000000, no flags.
- Abort: `rst_FSM` asserted 2 cycles after start → `ready` stays 0; the next start completes normally.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and helpers for the floating-point add/subtract unit.
// Contents: FSM state enum, r_mode encodings, exponent/fraction width helpers.
package fpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } fsm_state_e;

  localparam logic [1:0] RM_TRUNC   = 2'b00;
  localparam logic [1:0] RM_NEG_INF = 2'b01;
  localparam logic [1:0] RM_POS_INF = 2'b10;
  localparam logic [1:0] RM_NEAREST = 2'b11;

  // Exponent width for a given word width (double for 64, single otherwise).
  function automatic int unsigned ew_of(input int unsigned w);
    return (w == 64) ? 11 : 8;
  endfunction

  // Stored fraction width (hidden bit excluded).
  function automatic int unsigned sw_of(input int unsigned w);
    return w - ew_of(w) - 1;
  endfunction

endpackage

// File: rtl/fpu_lzd.sv
// Combinational leading-zero detector.
// Ports: vec_i (N-bit vector), lz_cnt_c (number of leading zeros, N when all zero).
module fpu_lzd #(
  parameter int unsigned N  = 28,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  vec_i,
  output logic [CW-1:0] lz_cnt_c
);

  // Highest set bit wins because it is visited last.
  always_comb begin
    lz_cnt_c = CW'(N);
    for (int i = 0; i < N; i++) begin
      if (vec_i[i]) lz_cnt_c = CW'(N - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_add_subtract_function.sv
// Multi-cycle IEEE-754 adder/subtractor (ALIGN/ADD/NORM/ROUND), start/ready handshake.
// Ports: clk, rst (sync whole block), rst_FSM (sync FSM/flags only), beg_FSM start,
//        Data_X/Data_Y operands, add_subt (1 = X-Y), r_mode rounding select,
//        overflow_flag/underflow_flag/ready/final_result_ieee registered outputs.
// Optional feature macro: FPU_ROUND_NEAREST_EN (r_mode 11 = nearest-even, else truncate).
module fpu_add_subtract_function
  import fpu_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rst_FSM,
  input  logic         beg_FSM,
  input  logic [W-1:0] Data_X,
  input  logic [W-1:0] Data_Y,
  input  logic         add_subt,
  input  logic [1:0]   r_mode,
  output logic         overflow_flag,
  output logic         underflow_flag,
  output logic         ready,
  output logic [W-1:0] final_result_ieee
);

  localparam int unsigned EW   = ew_of(W);
  localparam int unsigned SW   = sw_of(W);
  localparam int unsigned SIGW = SW + 4;  // hidden + fraction + guard/round/sticky
  localparam int unsigned SUMW = SW + 5;  // plus carry
  localparam int unsigned LZW  = $clog2(SUMW + 1);
  localparam int unsigned XW   = EW + 2;  // signed exponent with headroom
  localparam int unsigned MW   = SW + 2;  // rounded mantissa with carry
  localparam int unsigned EMAX = (1 << EW) - 1;

  fsm_state_e state_q, state_d;
  logic [W-1:0] x_q, x_d, y_q, y_d;
  logic op_q, op_d;
  logic [1:0] rm_q, rm_d;
  logic sa_q, sa_d, eff_sub_q, eff_sub_d;
  logic [EW-1:0] exp_a_q, exp_a_d;
  logic [SIGW-1:0] sig_a_q, sig_a_d, sig_b_q, sig_b_d;
  logic [SUMW-1:0] sum_q, sum_d;
  logic [SIGW-1:0] norm_q, norm_d;
  logic signed [XW-1:0] exp_n_q, exp_n_d;
  logic [W-1:0] res_q, res_d, result_q, result_d;
  logic ovf_q, ovf_d, udf_q, udf_d;
  logic ovf_out_q, ovf_out_d, udf_out_q, udf_out_d, ready_q, ready_d;

  assign overflow_flag     = ovf_out_q;
  assign underflow_flag    = udf_out_q;
  assign ready             = ready_q;
  assign final_result_ieee = result_q;

  // ALIGN: order operands by magnitude and shift the smaller one right.
  logic sx_c, sy_c, swap_c, a_sign_c, b_lost_c;
  logic [W-2:0] mag_x_c, mag_y_c;
  logic [EW-1:0] a_exp_c, b_exp_c, diff_c;
  logic [SIGW-1:0] a_sig_c, b_sig_c, b_al_c;

  always_comb begin
    sx_c     = x_q[W-1];
    sy_c     = y_q[W-1] ^ op_q;
    // Denormals are flushed to zero before comparison.
    mag_x_c  = (x_q[W-2 -: EW] == '0) ? '0 : x_q[W-2:0];
    mag_y_c  = (y_q[W-2 -: EW] == '0) ? '0 : y_q[W-2:0];
    swap_c   = mag_y_c > mag_x_c;
    a_sign_c = swap_c ? sy_c : sx_c;
    a_exp_c  = swap_c ? mag_y_c[W-2 -: EW] : mag_x_c[W-2 -: EW];
    b_exp_c  = swap_c ? mag_x_c[W-2 -: EW] : mag_y_c[W-2 -: EW];
    a_sig_c  = (a_exp_c == '0) ? '0 :
               {1'b1, (swap_c ? mag_y_c[SW-1:0] : mag_x_c[SW-1:0]), 3'b000};
    b_sig_c  = (b_exp_c == '0) ? '0 :
               {1'b1, (swap_c ? mag_x_c[SW-1:0] : mag_y_c[SW-1:0]), 3'b000};
    diff_c   = a_exp_c - b_exp_c;
    b_lost_c = |(b_sig_c & ~({SIGW{1'b1}} << diff_c));
    if (32'(diff_c) >= SW + 3) b_al_c = SIGW'(|b_sig_c);
    else                       b_al_c = (b_sig_c >> diff_c) | SIGW'(b_lost_c);
  end

  // NORM: carry shifts right, otherwise bring the leading one to the hidden position.
  logic [LZW-1:0] lz_c, sh_c;
  logic [SIGW-1:0] norm_c;
  logic signed [XW-1:0] exp_ext_c, exp_n_c;

  fpu_lzd #(.N(SUMW), .CW(LZW)) u_lzd (
    .vec_i    (sum_q),
    .lz_cnt_c (lz_c)
  );

  always_comb begin
    exp_ext_c = $signed(XW'(exp_a_q));
    sh_c      = lz_c - LZW'(1);
    if (sum_q[SUMW-1]) begin
      norm_c  = {sum_q[SUMW-1:2], sum_q[1] | sum_q[0]};
      exp_n_c = exp_ext_c + $signed(XW'(1));
    end else begin
      norm_c  = SIGW'(sum_q << sh_c);
      exp_n_c = exp_ext_c - $signed(XW'(sh_c));
    end
  end

  // ROUND: directed rounding, then exponent range check and packing.
  logic inc_c, any_c;
  logic [MW-1:0] mant_r_c;
  logic signed [XW-1:0] exp_r_c;
  logic [W-1:0] res_c;
  logic ovf_c, udf_c;

  always_comb begin
    any_c = |norm_q[2:0];
    inc_c = 1'b0;
    case (rm_q)
      RM_NEG_INF: inc_c = sa_q & any_c;
      RM_POS_INF: inc_c = ~sa_q & any_c;
`ifdef FPU_ROUND_NEAREST_EN
      RM_NEAREST: inc_c = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
`endif
      default:    inc_c = 1'b0;
    endcase
    mant_r_c = {1'b0, norm_q[SIGW-1:3]} + MW'(inc_c);
    exp_r_c  = exp_n_q + $signed(XW'(mant_r_c[MW-1]));
    ovf_c    = 1'b0;
    udf_c    = 1'b0;
    // A zero sum leaves no bit at the hidden position or above.
    if (!(mant_r_c[MW-1] | mant_r_c[MW-2])) begin
      res_c = '0;
    end else if (exp_r_c >= $signed(XW'(EMAX))) begin
      res_c = {sa_q, {EW{1'b1}}, {SW{1'b0}}};
      ovf_c = 1'b1;
    end else if (exp_r_c <= $signed(XW'(0))) begin
      res_c = {sa_q, {(W-1){1'b0}}};
      udf_c = 1'b1;
    end else begin
      res_c = {sa_q, exp_r_c[EW-1:0], mant_r_c[SW-1:0]};
    end
  end

  // FSM next state and register loads.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    op_d      = op_q;
    rm_d      = rm_q;
    sa_d      = sa_q;
    eff_sub_d = eff_sub_q;
    exp_a_d   = exp_a_q;
    sig_a_d   = sig_a_q;
    sig_b_d   = sig_b_q;
    sum_d     = sum_q;
    norm_d    = norm_q;
    exp_n_d   = exp_n_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    result_d  = result_q;
    ovf_out_d = ovf_out_q;
    udf_out_d = udf_out_q;
    ready_d   = ready_q;
    unique case (state_q)
      ST_ALIGN: begin
        sa_d      = a_sign_c;
        eff_sub_d = sx_c ^ sy_c;
        exp_a_d   = a_exp_c;
        sig_a_d   = a_sig_c;
        sig_b_d   = b_al_c;
        state_d   = ST_ADD;
      end
      ST_ADD: begin
        sum_d   = eff_sub_q ? ({1'b0, sig_a_q} - {1'b0, sig_b_q})
                            : ({1'b0, sig_a_q} + {1'b0, sig_b_q});
        state_d = ST_NORM;
      end
      ST_NORM: begin
        norm_d  = norm_c;
        exp_n_d = exp_n_c;
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        res_d   = res_c;
        ovf_d   = ovf_c;
        udf_d   = udf_c;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        result_d  = res_q;
        ovf_out_d = ovf_q;
        udf_out_d = udf_q;
        ready_d   = 1'b1;
      end
      default: ;
    endcase
    if ((state_q == ST_IDLE || state_q == ST_DONE) && beg_FSM) begin
      x_d     = Data_X;
      y_d     = Data_Y;
      op_d    = add_subt;
      rm_d    = r_mode;
      ready_d = 1'b0;
      state_d = ST_ALIGN;
    end
  end

  // State and datapath registers; rst_FSM clears only control and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      op_q      <= 1'b0;
      rm_q      <= RM_TRUNC;
      sa_q      <= 1'b0;
      eff_sub_q <= 1'b0;
      exp_a_q   <= '0;
      sig_a_q   <= '0;
      sig_b_q   <= '0;
      sum_q     <= '0;
      norm_q    <= '0;
      exp_n_q   <= '0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      result_q  <= '0;
      ovf_out_q <= 1'b0;
      udf_out_q <= 1'b0;
      ready_q   <= 1'b0;
    end else if (rst_FSM) begin
      state_q   <= ST_IDLE;
      ovf_out_q <= 1'b0;
      udf_out_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      op_q      <= op_d;
      rm_q      <= rm_d;
      sa_q      <= sa_d;
      eff_sub_q <= eff_sub_d;
      exp_a_q   <= exp_a_d;
      sig_a_q   <= sig_a_d;
      sig_b_q   <= sig_b_d;
      sum_q     <= sum_d;
      norm_q    <= norm_d;
      exp_n_q   <= exp_n_d;
      res_q     <= res_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      result_q  <= result_d;
      ovf_out_q <= ovf_out_d;
      udf_out_q <= udf_out_d;
      ready_q   <= ready_d;
    end
  end

endmodule

// File: tb/tb_fpu_add_subtract_function.sv
// Self-checking bench for fpu_add_subtract_function (single precision).
// Vector table plus scoreboard queue; hand sequences for abort and mid-op start.
module tb_fpu_add_subtract_function;

  logic        clk = 1'b0;
  logic        rst, rst_FSM, beg_FSM, add_subt;
  logic [1:0]  r_mode;
  logic [31:0] Data_X, Data_Y;
  logic        overflow_flag, underflow_flag, ready;
  logic [31:0] final_result_ieee;

  fpu_add_subtract_function #(.W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .rst_FSM           (rst_FSM),
    .beg_FSM           (beg_FSM),
    .Data_X            (Data_X),
    .Data_Y            (Data_Y),
    .add_subt          (add_subt),
    .r_mode            (r_mode),
    .overflow_flag     (overflow_flag),
    .underflow_flag    (underflow_flag),
    .ready             (ready),
    .final_result_ieee (final_result_ieee)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        op;
    logic [1:0]  rm;
    logic [31:0] res;
    logic        ovf;
    logic        udf;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        udf;
  } exp_t;

  localparam int NV = 13;
  vec_t vecs[NV];
  exp_t sb_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Drive one start pulse and record the expected outcome.
  task automatic start_op(input vec_t v);
    exp_t e;
    @(negedge clk);
    Data_X   = v.x;
    Data_Y   = v.y;
    add_subt = v.op;
    r_mode   = v.rm;
    beg_FSM  = 1'b1;
    e.res = v.res;
    e.ovf = v.ovf;
    e.udf = v.udf;
    sb_q.push_back(e);
    @(negedge clk);
    beg_FSM = 1'b0;
  endtask

  // Called lat0 edges after the start edge; expects ready exactly 5 edges after it.
  task automatic wait_ready(input string name, input int lat0);
    int   lat;
    exp_t e;
    lat = lat0;
    while (!ready && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd5);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard: got empty queue expected entry", name);
    end else begin
      e = sb_q.pop_front();
      check({name, "_result"}, final_result_ieee, e.res);
      check({name, "_flags"}, {30'd0, overflow_flag, underflow_flag}, {30'd0, e.ovf, e.udf});
    end
  endtask

  initial begin
    vec_t v;
    logic seen;
    vecs[0]  = '{32'h40066666, 32'h40466666, 1'b0, 2'b01, 32'h40A66666, 1'b0, 1'b0};
    vecs[1]  = '{32'h40066666, 32'h40466666, 1'b1, 2'b00, 32'hBF800000, 1'b0, 1'b0};
    vecs[2]  = '{32'h40466666, 32'h40066666, 1'b1, 2'b00, 32'h3F800000, 1'b0, 1'b0};
    vecs[3]  = '{32'h3F800000, 32'h33800001, 1'b0, 2'b00, 32'h3F800000, 1'b0, 1'b0};
    vecs[4]  = '{32'h3F800000, 32'h33800001, 1'b0, 2'b10, 32'h3F800001, 1'b0, 1'b0};
    vecs[5]  = '{32'h3F800000, 32'h33800001, 1'b0, 2'b01, 32'h3F800000, 1'b0, 1'b0};
`ifdef FPU_ROUND_NEAREST_EN
    vecs[6]  = '{32'h3F800000, 32'h33800001, 1'b0, 2'b11, 32'h3F800001, 1'b0, 1'b0};
`else
    vecs[6]  = '{32'h3F800000, 32'h33800001, 1'b0, 2'b11, 32'h3F800000, 1'b0, 1'b0};
`endif
    vecs[7]  = '{32'h3F800000, 32'h00800000, 1'b0, 2'b10, 32'h3F800001, 1'b0, 1'b0};
    vecs[8]  = '{32'hBF800000, 32'h00800000, 1'b0, 2'b01, 32'hBF800000, 1'b0, 1'b0};
    vecs[9]  = '{32'hBF800000, 32'h00800000, 1'b0, 2'b00, 32'hBF7FFFFF, 1'b0, 1'b0};
    vecs[10] = '{32'h00800001, 32'h00800000, 1'b1, 2'b00, 32'h00000000, 1'b0, 1'b1};
    vecs[11] = '{32'h40066666, 32'hC0066666, 1'b0, 2'b00, 32'h00000000, 1'b0, 1'b0};
    vecs[12] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b00, 32'h7F800000, 1'b1, 1'b0};

    rst = 1'b1; rst_FSM = 1'b0; beg_FSM = 1'b0; add_subt = 1'b0;
    r_mode = 2'b00; Data_X = '0; Data_Y = '0;
    @(posedge clk);
    #1;
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_flags", {30'd0, overflow_flag, underflow_flag}, 32'd0);
    check("reset_result", final_result_ieee, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      start_op(vecs[i]);
      wait_ready($sformatf("vec%0d", i), 0);
    end

    // Abort two cycles after start; flags clear, result keeps the overflow value.
    v = vecs[0];
    start_op(v);
    void'(sb_q.pop_back());
    @(negedge clk);
    rst_FSM = 1'b1;
    @(negedge clk);
    rst_FSM = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      seen |= ready;
    end
    check("abort_ready", {31'd0, seen}, 32'd0);
    check("abort_flags", {30'd0, overflow_flag, underflow_flag}, 32'd0);
    check("abort_result", final_result_ieee, 32'h7F800000);

    // Start after abort, with a second start pulse during ALIGN that must be ignored.
    start_op(vecs[2]);
    Data_X   = 32'h7F7FFFFF;
    Data_Y   = 32'h7F7FFFFF;
    add_subt = 1'b0;
    beg_FSM  = 1'b1;
    @(negedge clk);
    beg_FSM = 1'b0;
    wait_ready("ignored_beg", 1);

    // Full reset clears outputs after a completed operation.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("final_reset_result", final_result_ieee, 32'h0);
    check("final_reset_ready", {31'd0, ready}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
